// File: rtl/sdram_port_client_if.sv
// sdram_port_client_if: one toggle-handshake SDRAM controller port.
// A request is outstanding while req != ack; the controller completes it
// by making ack equal to req, with q valid in that same cycle.
interface sdram_port_client_if;
    logic        req;
    logic        ack;
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [15:0] q;

    modport master (output req, we, a, ds, d, input ack, q);
    modport slave  (input req, we, a, ds, d, output ack, q);
endinterface

// File: rtl/sdram_port_client.sv
// sdram_port_client: bridges an 8-bit strobe-driven CPU/DMA bus onto one
// toggle-handshake SDRAM controller port (16-bit words). Issues toggle
// requests, steers bytes, and abandons a request if no ack arrives within
// TIMEOUT cycles.
// Optional build macro SDRAM_PORT_CLIENT_RCACHE_EN adds a one-word
// write-through read cache; without it every read goes to the port.
module sdram_port_client #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [23:0] cpu_addr_i,
    input  logic [7:0]  cpu_din_i,
    output logic [7:0]  cpu_dout_o,
    output logic        cpu_dout_valid_o,
    output logic        cpu_busy_o,
    output logic        err_timeout_o,
    output logic        err_overrun_o,
    sdram_port_client_if.master port
);
    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_WAIT_ACK} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [22:0]   a_q, a_d;
    logic [1:0]    ds_q, ds_d;
    logic [15:0]   d_q, d_d;
    logic [7:0]    dout_q, dout_d;
    logic          dvld_q, dvld_d;
    logic          to_q, to_d;
    logic          ov_q, ov_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic strobe;
    logic acked;
    logic issue;

    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign strobe = cpu_rd_i | cpu_wr_i;
    assign acked  = (port.ack == req_q);

`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
    logic        cvld_q, cvld_d;
    logic [22:0] ctag_q, ctag_d;
    logic [15:0] cdat_q, cdat_d;
    logic        chit;
    logic        serve;

    assign chit  = cvld_q && (ctag_q == cpu_addr_i[23:1]);
    // A pure read that hits is answered locally; write wins over read.
    assign serve = cpu_rd_i && !cpu_wr_i && chit;
    assign issue = strobe && !serve;
`else
    assign issue = strobe;
`endif

    // Next-state and register-update logic for the request FSM.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        a_d     = a_q;
        ds_d    = ds_q;
        d_d     = d_q;
        dout_d  = dout_q;
        dvld_d  = 1'b0;
        to_d    = to_q;
        ov_d    = ov_q;
        tmr_d   = tmr_q;
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
        cvld_d  = cvld_q;
        ctag_d  = ctag_q;
        cdat_d  = cdat_q;
`endif
        case (state_q)
            ST_SYNC: begin
                // Adopt whatever ack the controller holds, so nothing is pending.
                req_d   = port.ack;
                state_d = ST_IDLE;
                if (strobe) ov_d = 1'b1;
            end
            ST_IDLE: begin
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
                if (serve) begin
                    dout_d = sel_byte(cdat_q, cpu_addr_i[0]);
                    dvld_d = 1'b1;
                end
                if (cpu_wr_i && chit) begin
                    if (cpu_addr_i[0]) cdat_d[15:8] = cpu_din_i;
                    else               cdat_d[7:0]  = cpu_din_i;
                end
`endif
                if (issue) begin
                    a_d     = cpu_addr_i[23:1];
                    ds_d    = cpu_addr_i[0] ? 2'b10 : 2'b01;
                    we_d    = cpu_wr_i;
                    d_d     = {cpu_din_i, cpu_din_i};
                    req_d   = ~req_q;
                    tmr_d   = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (strobe) ov_d = 1'b1;
                if (acked) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        dout_d = sel_byte(port.q, ds_q[1]);
                        dvld_d = 1'b1;
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
                        cvld_d = 1'b1;
                        ctag_d = a_q;
                        cdat_d = port.q;
`endif
                    end
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    // Abandon: re-align req to ack so a late ack changes nothing.
                    to_d    = 1'b1;
                    req_d   = port.ack;
                    state_d = ST_IDLE;
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
                    cvld_d  = 1'b0;
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // State, bus and status registers; reset returns to SYNC and drops any pending work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            we_q    <= 1'b0;
            a_q     <= '0;
            ds_q    <= '0;
            d_q     <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            to_q    <= 1'b0;
            ov_q    <= 1'b0;
            tmr_q   <= '0;
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
            cvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            a_q     <= a_d;
            ds_q    <= ds_d;
            d_q     <= d_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            to_q    <= to_d;
            ov_q    <= ov_d;
            tmr_q   <= tmr_d;
`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
            cvld_q  <= cvld_d;
`endif
        end
    end

    // Request toggle is held through reset and re-aligned to ack in SYNC.
    always_ff @(posedge clk) begin
        if (!reset) req_q <= req_d;
    end

`ifdef SDRAM_PORT_CLIENT_RCACHE_EN
    // Cached word and tag are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        ctag_q <= ctag_d;
        cdat_q <= cdat_d;
    end
`endif

    assign port.req         = req_q;
    assign port.we          = we_q;
    assign port.a           = a_q;
    assign port.ds          = ds_q;
    assign port.d           = d_q;
    assign cpu_dout_o       = dout_q;
    assign cpu_dout_valid_o = dvld_q;
    assign cpu_busy_o       = (state_q != ST_IDLE);
    assign err_timeout_o    = to_q;
    assign err_overrun_o    = ov_q;
endmodule
